// File: rtl/cpu_pkg.sv
// Shared scalar-pipeline types: ALU opcode encoding and the architectural flag layout.
package cpu_pkg;

    localparam int FLAG_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_XORI = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_SLT  = 3'b011,
        ALU_SLL  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_MUL  = 3'b110,
        ALU_ZERO = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
        logic gt;
    } flags_t;

endpackage

// File: rtl/alu.sv
// Combinational scalar ALU. Only add/sub/mul produce flags; every other op reports all-zero flags.
module alu
    import cpu_pkg::*;
#(
    parameter int N = 24
) (
    input  alu_op_t      op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output flags_t       flags
);

    logic [N:0]              sum;
    logic [N:0]              diff;
    logic [2*N-1:0]          prod_u;
    logic signed [2*N-1:0]   prod_s;
    logic [4:0]              shamt;
    logic                    arith;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    assign prod_u = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    assign prod_s = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
    assign shamt  = b[7:3];

    // Carry on sub is "no borrow" (a >= b unsigned); mul carry/overflow flag lost high bits.
    always_comb begin
        result = '0;
        flags  = '0;
        arith  = 1'b0;
        case (op)
            ALU_ADD: begin
                result  = sum[N-1:0];
                flags.c = sum[N];
                flags.v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
                arith   = 1'b1;
            end
            ALU_XORI: result = a ^ b;
            ALU_SUB: begin
                result  = diff[N-1:0];
                flags.c = diff[N];
                flags.v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
                arith   = 1'b1;
            end
            ALU_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_MUL: begin
                result  = prod_u[N-1:0];
                flags.c = |prod_u[2*N-1:N];
                flags.v = (prod_s != {{N{prod_s[N-1]}}, prod_s[N-1:0]});
                arith   = 1'b1;
            end
            default: result = '0;
        endcase
        if (arith) begin
            flags.n = result[N-1];
            flags.z = (result == '0);
        end
        if (op == ALU_SUB) begin
            flags.gt = ~flags.n & ~flags.v & ~flags.z;
        end
    end

endmodule

// File: rtl/ex_skid_buffer.sv
// Two-entry valid/ready buffer: a main output slot plus one skid entry so in_ready never depends on out_ready.
module ex_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         drain;

    assign in_ready = ~skid_valid & ~flush;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    // A full skid always refills the main slot before anything new is taken, preserving order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_data  <= in_data;
                skid_valid <= 1'b1;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/scalar_ex_stage.sv
// Execute stage: ALU on accepted ops, result/destination into a skid-buffered EX/WB slot,
// and the architectural flag register committed at accept time.
module scalar_ex_stage
    import cpu_pkg::*;
#(
    parameter int N        = 24,
    parameter int REG_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  alu_op_t             in_op,
    input  logic [N-1:0]        in_a,
    input  logic [N-1:0]        in_b,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic                in_we,
    input  logic                in_setflags,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_result,
    output logic [REG_BITS-1:0] out_rd,
    output logic                out_we,
    output logic [FLAG_W-1:0]   flags_q,
    output logic                fwd_valid
);

    localparam int W = N + REG_BITS + 1;

    logic [N-1:0] alu_result;
    flags_t       alu_flags;
    logic [W-1:0] slot_data;
    logic         accept;

    alu #(.N(N)) u_alu (
        .op     (in_op),
        .a      (in_a),
        .b      (in_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    ex_skid_buffer #(.W(W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({alu_result, in_rd, in_we}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (slot_data)
    );

    assign accept = in_valid & in_ready;
    assign {out_result, out_rd, out_we} = slot_data;
    assign fwd_valid = out_valid & out_we;

    // Flags follow accept order, not writeback order, so branches see them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else if (accept && in_setflags) begin
            flags_q <= alu_flags;
        end
    end

endmodule

// File: tb/tb_scalar_ex_stage.sv
// Self-checking bench for scalar_ex_stage: directed vector table, reset/backpressure/flush
// sequences, and a random back-to-back stream checked against an arithmetic reference model.
module tb_scalar_ex_stage;
    import cpu_pkg::*;

    localparam int N  = 24;
    localparam int RB = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    alu_op_t       in_op;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic [RB-1:0] in_rd;
    logic          in_we;
    logic          in_setflags;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic [RB-1:0] out_rd;
    logic          out_we;
    logic [4:0]    flags_q;
    logic          fwd_valid;

    int tests = 0;
    int fails = 0;

    scalar_ex_stage #(.N(N), .REG_BITS(RB)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .in_we       (in_we),
        .in_setflags (in_setflags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .flags_q     (flags_q),
        .fwd_valid   (fwd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sf;
        logic [N-1:0] res;
        logic [4:0]   flags;
    } vec_t;

    vec_t vecs[12];

    // Reference ALU from plain integer arithmetic: range checks for overflow, magnitude for carry.
    function automatic void refModel(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                     output logic [N-1:0] res, output logic [4:0] fl);
        longint ua, ub, sa, sb, full, sfull, maxu, smax, smin;
        int     sh;
        bit     arith, n, z, c, v, gt;
        maxu  = (longint'(1) << N) - 1;
        smax  = (longint'(1) << (N - 1)) - 1;
        smin  = -(longint'(1) << (N - 1));
        ua    = longint'(a);
        ub    = longint'(b);
        sa    = a[N-1] ? ua - (longint'(1) << N) : ua;
        sb    = b[N-1] ? ub - (longint'(1) << N) : ub;
        sh    = int'(b[7:3]);
        arith = 0; c = 0; v = 0; full = 0; sfull = 0;
        case (op)
            3'd0: begin full = ua + ub; sfull = sa + sb; c = (full > maxu); arith = 1; end
            3'd1: full = ua ^ ub;
            3'd2: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub); arith = 1; end
            3'd3: full = (sa < sb) ? 1 : 0;
            3'd4: full = ua << sh;
            3'd5: full = ua >> sh;
            3'd6: begin full = ua * ub; sfull = sa * sb; c = (full > maxu); arith = 1; end
            default: full = 0;
        endcase
        if (arith) v = (sfull > smax) || (sfull < smin);
        full = full & maxu;
        res  = full[N-1:0];
        n    = arith && res[N-1];
        z    = arith && (res == 0);
        gt   = (op == 3'd2) && !n && !v && !z;
        fl   = {n, z, c, v, gt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic [RB-1:0] rd,
                                 input logic we, input logic sf);
        in_valid    = v;
        in_op       = alu_op_t'(op);
        in_a        = a;
        in_b        = b;
        in_rd       = rd;
        in_we       = we;
        in_setflags = sf;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] eres;
        logic [4:0]   efl;
        logic [4:0]   model_flags;
        logic [2:0]   rop;
        logic [N-1:0] ra, rb;
        logic         rsf;

        vecs[0]  = '{3'd0, 24'h000001, 24'h000002, 1'b1, 24'h000003, 5'b00000};
        vecs[1]  = '{3'd0, 24'h7FFFFF, 24'h000001, 1'b1, 24'h800000, 5'b10010};
        vecs[2]  = '{3'd2, 24'h000005, 24'h000003, 1'b1, 24'h000002, 5'b00101};
        vecs[3]  = '{3'd2, 24'h000003, 24'h000003, 1'b1, 24'h000000, 5'b01100};
        vecs[4]  = '{3'd0, 24'h00000A, 24'h000014, 1'b0, 24'h00001E, 5'b01100};
        vecs[5]  = '{3'd1, 24'h0F0F0F, 24'hFFFFFF, 1'b1, 24'hF0F0F0, 5'b00000};
        vecs[6]  = '{3'd3, 24'hFFFFFF, 24'h000001, 1'b1, 24'h000001, 5'b00000};
        vecs[7]  = '{3'd4, 24'h000001, 24'h000008, 1'b0, 24'h000002, 5'b00000};
        vecs[8]  = '{3'd5, 24'h800000, 24'h0000B8, 1'b0, 24'h000001, 5'b00000};
        vecs[9]  = '{3'd6, 24'h001000, 24'h001000, 1'b1, 24'h000000, 5'b01110};
        vecs[10] = '{3'd7, 24'h123456, 24'h654321, 1'b1, 24'h000000, 5'b00000};
        vecs[11] = '{3'd2, 24'h000003, 24'h000005, 1'b1, 24'hFFFFFE, 5'b10000};

        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        #12;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset flags_q", 32'(flags_q), 32'd0);
        checkOutput("reset out_result", 32'(out_result), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table, one op at a time with writeback always ready.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, RB'(i), i[0], vecs[i].sf);
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            step();
            applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d result", i), 32'(out_result), 32'(vecs[i].res));
            checkOutput($sformatf("vec%0d flags", i), 32'(flags_q), 32'(vecs[i].flags));
            checkOutput($sformatf("vec%0d rd", i), 32'(out_rd), 32'(i % 16));
            checkOutput($sformatf("vec%0d fwd_valid", i), 32'(fwd_valid), 32'(i[0]));
            step();
        end
        checkOutput("drained out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a held result.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 24'd4, 24'd4, 4'd1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("async reset flags_q", 32'(flags_q), 32'd0);
        checkOutput("async reset out_result", 32'(out_result), 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 3'd0, 24'd1, 24'd2, 4'd2, 1'b1, 1'b1);
        step();
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("post-reset out_valid", 32'(out_valid), 32'd1);
        checkOutput("post-reset result", 32'(out_result), 32'd3);
        step();

        // Backpressure: two ops buffered, third stalls, then results drain in order.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 24'd1, 24'd1, 4'd3, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 3'd2, 24'd9, 24'd4, 4'd4, 1'b1, 1'b0);
        checkOutput("bp second in_ready", 32'(in_ready), 32'd1);
        step();
        applyStimulus(1'b1, 3'd4, 24'd1, 24'h08, 4'd5, 1'b1, 1'b0);
        checkOutput("bp third in_ready", 32'(in_ready), 32'd0);
        step();
        checkOutput("bp stalled in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp held result", 32'(out_result), 32'd2);
        checkOutput("bp held rd", 32'(out_rd), 32'd3);
        out_ready = 1'b1;
        step();
        checkOutput("bp result 2", 32'(out_result), 32'd5);
        checkOutput("bp ready after skid move", 32'(in_ready), 32'd1);
        step();
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("bp result 3 valid", 32'(out_valid), 32'd1);
        checkOutput("bp result 3", 32'(out_result), 32'd2);
        checkOutput("bp result 3 rd", 32'(out_rd), 32'd5);
        step();
        checkOutput("bp drained", 32'(out_valid), 32'd0);

        // Flush squashes both entries even with out_ready high; flags survive.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd2, 24'd2, 24'd7, 4'd6, 1'b1, 1'b1);
        step();
        applyStimulus(1'b1, 3'd0, 24'd1, 24'd1, 4'd7, 1'b1, 1'b0);
        step();
        checkOutput("flush pre in_ready", 32'(in_ready), 32'd0);
        checkOutput("flush pre flags", 32'(flags_q), 32'b10000);
        applyStimulus(1'b1, 3'd2, 24'd3, 24'd3, 4'd8, 1'b1, 1'b1);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("flush in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("flush out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush flags kept", 32'(flags_q), 32'b10000);
        step();
        checkOutput("flush stays empty", 32'(out_valid), 32'd0);

        // Random back-to-back stream: one result per cycle against the reference model.
        model_flags = 5'b10000;
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = N'($urandom);
            rb  = N'($urandom);
            rsf = 1'($urandom_range(0, 1));
            refModel(rop, ra, rb, eres, efl);
            if (rsf) model_flags = efl;
            applyStimulus(1'b1, rop, ra, rb, RB'(i), 1'b1, rsf);
            checkOutput($sformatf("rnd%0d in_ready", i), 32'(in_ready), 32'd1);
            step();
            checkOutput($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("rnd%0d op%0d result", i, rop), 32'(out_result), 32'(eres));
            checkOutput($sformatf("rnd%0d op%0d flags", i, rop), 32'(flags_q), 32'(model_flags));
        end
        applyStimulus(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
        step();
        checkOutput("rnd drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
